nibble_add_seq: RTL and testbench



---
 rtl/nibble_add_seq.sv | 132 +++++++++++++
 tb/tb_nibble_add_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_seq.sv
// Wide adder built around an external 4-bit adder slice: the operands are fed
// through the slice one nibble at a time, LS nibble first, and the ripple carry is chained between nibbles.
module nibble_add_seq #(
  parameter int W   = 16,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout
);

  localparam int NIB = W / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int WW  = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  sum_r;
  logic [W-1:0]  sum_next_s;
  logic          sa_r;
  logic          sb_r;
  logic [IW-1:0] idx_r;
  logic [WW-1:0] wait_r;
  logic          sample_s;
  logic          last_s;

  function automatic logic ovf_f(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  assign in_ready = (state_r == IDLE) && !rst;

  // Merge the slice's nibble into the partial sum and decode sample/last conditions
  always_comb begin
    sum_next_s = sum_r;
    sum_next_s[{idx_r, 2'b00} +: 4] = add_sum;
    sample_s = (wait_r == WW'(LAT));
    last_s   = (idx_r == IW'(NIB - 1));
  end

  // Sequencer: accept, step through the nibbles, then hold the result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      sa_r      <= 1'b0;
      sb_r      <= 1'b0;
      idx_r     <= '0;
      wait_r    <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      add_a     <= 4'd0;
      add_b     <= 4'd0;
      add_cin   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // a_r/b_r hold the not-yet-presented nibbles, shifted down as they are used
            a_r     <= in_a >> 3'd4;
            b_r     <= in_b >> 3'd4;
            sa_r    <= in_a[W-1];
            sb_r    <= in_b[W-1];
            add_a   <= in_a[3:0];
            add_b   <= in_b[3:0];
            add_cin <= in_cin;
            idx_r   <= '0;
            wait_r  <= '0;
            state_r <= RUN;
          end
        end
        RUN: begin
          if (sample_s) begin
            sum_r <= sum_next_s;
            if (last_s) begin
              out_sum   <= sum_next_s;
              out_cout  <= add_cout;
              out_ovf   <= ovf_f(sa_r, sb_r, add_sum[3]);
              out_valid <= 1'b1;
              state_r   <= DONE;
            end else begin
              add_a   <= a_r[3:0];
              add_b   <= b_r[3:0];
              add_cin <= add_cout;
              a_r     <= a_r >> 3'd4;
              b_r     <= b_r >> 3'd4;
              idx_r   <= idx_r + IW'(1);
              wait_r  <= '0;
            end
          end else begin
            wait_r <= wait_r + WW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq: a W=16/LAT=2 instance driven from a vector table
// plus corner sequences, and a W=8/LAT=0 instance under random traffic.
module tb_nibble_add_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        in0_valid, in0_ready, in0_cin, out0_valid, out0_ready, out0_cout, out0_ovf;
  logic [15:0] in0_a, in0_b, out0_sum;
  logic [3:0]  add0_a, add0_b, add0_sum;
  logic        add0_cin, add0_cout;
  logic [4:0]  pipe0_1, pipe0_2;

  logic        in1_valid, in1_ready, in1_cin, out1_valid, out1_ready, out1_cout, out1_ovf;
  logic [7:0]  in1_a, in1_b, out1_sum;
  logic [3:0]  add1_a, add1_b, add1_sum;
  logic        add1_cin, add1_cout;

  nibble_add_seq #(.W(16), .LAT(2)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in0_valid), .in_ready(in0_ready), .in_a(in0_a), .in_b(in0_b), .in_cin(in0_cin),
    .out_valid(out0_valid), .out_ready(out0_ready), .out_sum(out0_sum),
    .out_cout(out0_cout), .out_ovf(out0_ovf),
    .add_a(add0_a), .add_b(add0_b), .add_cin(add0_cin),
    .add_sum(add0_sum), .add_cout(add0_cout)
  );

  nibble_add_seq #(.W(8), .LAT(0)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in1_valid), .in_ready(in1_ready), .in_a(in1_a), .in_b(in1_b), .in_cin(in1_cin),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_sum(out1_sum),
    .out_cout(out1_cout), .out_ovf(out1_ovf),
    .add_a(add1_a), .add_b(add1_b), .add_cin(add1_cin),
    .add_sum(add1_sum), .add_cout(add1_cout)
  );

  // Two-stage registered slice for the LAT=2 instance
  always @(posedge clk) begin
    pipe0_1 <= {1'b0, add0_a} + {1'b0, add0_b} + {4'b0, add0_cin};
    pipe0_2 <= pipe0_1;
  end
  assign {add0_cout, add0_sum} = pipe0_2;

  assign {add1_cout, add1_sum} = {1'b0, add1_a} + {1'b0, add1_b} + {4'b0, add1_cin};

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          hold;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One operation on the LAT=2 instance; checks per-cycle slice drive, latency, result and handoff
  task automatic run_op0(input vec_t v);
    int         k;
    int         nib;
    logic [31:0] m;
    logic [31:0] ca;
    bit         seen;
    chk("ready_idle", 64'(in0_ready), 64'(1));
    in0_a = v.a; in0_b = v.b; in0_cin = v.cin; in0_valid = 1'b1;
    @(negedge clk);
    in0_valid = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      if (out0_valid) begin
        seen = 1'b1;
      end else begin
        if (k < 12) begin
          nib = k / 3;
          m   = 32'd1 << (4 * nib);
          ca  = ((32'(v.a) % m) + (32'(v.b) % m) + 32'(v.cin)) >> (4 * nib);
          chk("slice_drive", 64'({in0_ready, add0_a, add0_b, add0_cin}),
              64'({1'b0, 4'(v.a >> (4 * nib)), 4'(v.b >> (4 * nib)), ca[0]}));
        end
        @(negedge clk);
        k++;
      end
    end
    chk("latency", 64'(k), 64'(12));
    chk("result", 64'({out0_valid, out0_sum, out0_cout, out0_ovf}),
        64'({1'b1, v.sum, v.cout, v.ovf}));
    in0_valid = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      in0_a = 16'($urandom);
      in0_b = 16'($urandom);
      in0_cin = 1'($urandom);
      @(negedge clk);
      chk("backpressure", 64'({out0_valid, in0_ready, out0_sum, out0_cout, out0_ovf}),
          64'({1'b1, 1'b0, v.sum, v.cout, v.ovf}));
      in0_valid = ~in0_valid;
    end
    in0_valid  = 1'b0;
    out0_ready = 1'b1;
    @(negedge clk);
    out0_ready = 1'b0;
    chk("handoff", 64'({out0_valid, in0_ready}), 64'({1'b0, 1'b1}));
  endtask

  vec_t        v;
  int          sv, gap, lat, hold;
  logic [7:0]  ra, rb;
  logic        rc, eovf;
  logic [8:0]  full;

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 5};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0};

    rst = 1'b1;
    in0_valid = 1'b0; out0_ready = 1'b0; in0_a = 16'h0; in0_b = 16'h0; in0_cin = 1'b0;
    in1_valid = 1'b0; out1_ready = 1'b0; in1_a = 8'h0; in1_b = 8'h0; in1_cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset0", 64'({out0_valid, out0_sum, out0_cout, out0_ovf, add0_a, add0_b, add0_cin, in0_ready}), 64'(0));
    chk("reset1", 64'({out1_valid, out1_sum, out1_cout, out1_ovf, add1_a, add1_b, add1_cin, in1_ready}), 64'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 64'({in0_ready, in1_ready}), 64'({1'b1, 1'b1}));
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_op0(vecs[i]);

    // Abort an operation while nibble 2 is in flight
    chk("ready_pre_abort", 64'(in0_ready), 64'(1));
    in0_a = 16'h1234; in0_b = 16'h4321; in0_cin = 1'b0; in0_valid = 1'b1;
    @(negedge clk);
    in0_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("nibble2_loaded", 64'({add0_a, add0_b}), 64'({4'h2, 4'h3}));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset", 64'({out0_valid, out0_sum, out0_cout, out0_ovf, add0_a, add0_b, add0_cin, in0_ready}), 64'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_abort", 64'(in0_ready), 64'(1));
    sv = 0;
    repeat (15) begin
      @(negedge clk);
      if (out0_valid) sv++;
    end
    chk("no_spurious_valid", 64'(sv), 64'(0));
    v = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0};
    run_op0(v);

    // Random traffic on the W=8, LAT=0 instance against plain arithmetic
    for (int n = 0; n < 1000; n++) begin
      gap = $urandom_range(0, 3);
      in1_valid = 1'b0;
      repeat (gap) @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      chk("rnd_ready", 64'(in1_ready), 64'(1));
      in1_a = ra; in1_b = rb; in1_cin = rc; in1_valid = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!out1_valid && lat < 20) begin
        in1_valid = 1'($urandom);
        in1_a = 8'($urandom);
        in1_b = 8'($urandom);
        in1_cin = 1'($urandom);
        @(negedge clk);
        lat++;
      end
      chk("rnd_latency", 64'(lat), 64'(2));
      full = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      eovf = (ra[7] == rb[7]) && (full[7] != ra[7]);
      chk("rnd_result", 64'({out1_sum, out1_cout, out1_ovf}), 64'({full[7:0], full[8], eovf}));
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        in1_valid = 1'($urandom);
        @(negedge clk);
      end
      chk("rnd_hold", 64'({out1_valid, in1_ready, out1_sum, out1_cout, out1_ovf}),
          64'({1'b1, 1'b0, full[7:0], full[8], eovf}));
      in1_valid  = 1'b0;
      out1_ready = 1'b1;
      @(negedge clk);
      out1_ready = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
